// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks every input vector of an external N_IN-input
// combinational function in ascending order, waits SETTLE+1 cycles per
// vector, samples f_in and assembles the captured truth table.
// Optional feature macro: SCAN_COMPARE_EN. When it is defined, the captured
// table is checked against `expected`, producing err_cnt, first_err and pass.
// When it is undefined, those three outputs are constant 0.
// The captured table is exported on port truth_table, because `table` is a
// reserved word in SystemVerilog.
// Legal parameter ranges: N_IN 1..4, SETTLE 0..3.

module truth_table_scanner #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_err
);

    localparam int unsigned N_VEC = 2 ** N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               scan_start;
    logic               cnt_dec;
    logic               capture;
    logic               advance;
    logic               last_vec;

    assign last_vec = (vec == N_IN'(N_VEC - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        scan_start = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    scan_start = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
                capture = 1'b1;
                if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Vector walk, settle counter, table capture and handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            vec         <= '0;
            truth_table <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy <= (state_d == S_WAIT) || (state_d == S_SAMPLE);
            done <= (state_d == S_DONE);
            if (scan_start) begin
                vec         <= '0;
                truth_table <= '0;
                cnt_q       <= CNT_W'(SETTLE);
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                truth_table[vec] <= f_in;
            end
            // vec stays on the last index after the final sample
            if (advance) begin
                vec   <= vec + N_IN'(1);
                cnt_q <= CNT_W'(SETTLE);
            end
        end
    end

`ifdef SCAN_COMPARE_EN
    logic mismatch;

    assign mismatch = (f_in != expected[vec]);

    // Running mismatch statistics; pass is only refreshed once a scan completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt   <= '0;
            first_err <= '0;
            pass      <= 1'b0;
        end else begin
            if (scan_start) begin
                err_cnt   <= '0;
                first_err <= '0;
            end else if (capture && mismatch) begin
                if (err_cnt == '0) begin
                    first_err <= vec;
                end
                if (err_cnt != ERR_W'(N_VEC)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
            if (state_q == S_DONE) begin
                pass <= (err_cnt == '0);
            end
        end
    end
`else
    logic unused_expected;

    // Comparison omitted: statistics tied off, expected has no effect
    assign unused_expected = ^expected;
    assign err_cnt         = '0;
    assign first_err       = '0;
    assign pass            = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (N_IN=3/SETTLE=1,
// N_IN=4/SETTLE=1, N_IN=2/SETTLE=0) driven by task-per-scenario stimulus and
// checked against a truth-table model built from the function definitions.

module tb_truth_table_scanner;

`ifdef SCAN_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: N_IN=3, SETTLE=1, f = A.B.C' + A'.C
    logic        a_start, a_f, a_busy, a_done, a_pass;
    logic [7:0]  a_exp, a_tt;
    logic [2:0]  a_vec, a_first;
    logic [3:0]  a_err;

    // Instance B: N_IN=4, SETTLE=1, f given by table b_fn
    logic        b_start, b_f, b_busy, b_done, b_pass;
    logic [15:0] b_exp, b_tt, b_fn;
    logic [3:0]  b_vec, b_first;
    logic [4:0]  b_err;

    // Instance C: N_IN=2, SETTLE=0, f given by table c_fn
    logic        c_start, c_f, c_busy, c_done, c_pass;
    logic [3:0]  c_exp, c_tt, c_fn;
    logic [1:0]  c_vec, c_first;
    logic [2:0]  c_err;

    function automatic logic f3(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (a & b & ~c) | (~a & c);
    endfunction

    function automatic logic [7:0] ref_tt3();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = f3(3'(i));
        return t;
    endfunction

    function automatic int popcnt16(input logic [15:0] x);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(x[i]);
        return n;
    endfunction

    function automatic int lowest16(input logic [15:0] x);
        for (int i = 0; i < 16; i++) if (x[i]) return i;
        return 0;
    endfunction

    assign a_f = f3(a_vec);
    assign b_f = b_fn[b_vec];
    assign c_f = c_fn[c_vec];

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .expected(a_exp), .f_in(a_f),
        .vec(a_vec), .busy(a_busy), .done(a_done), .truth_table(a_tt),
        .pass(a_pass), .err_cnt(a_err), .first_err(a_first)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .expected(b_exp), .f_in(b_f),
        .vec(b_vec), .busy(b_busy), .done(b_done), .truth_table(b_tt),
        .pass(b_pass), .err_cnt(b_err), .first_err(b_first)
    );

    truth_table_scanner #(.N_IN(2), .SETTLE(0)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .expected(c_exp), .f_in(c_f),
        .vec(c_vec), .busy(c_busy), .done(c_done), .truth_table(c_tt),
        .pass(c_pass), .err_cnt(c_err), .first_err(c_first)
    );

    // Start a scan on A; report the edge index (from the accepting edge) at which done is seen
    task automatic scan_a(output int done_cyc, output logic busy_after_start, output logic done_next);
        done_cyc = -1;
        @(negedge clk) a_start = 1'b1;
        @(posedge clk);
        @(negedge clk) a_start = 1'b0;
        busy_after_start = a_busy;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_done) begin
                done_cyc = k;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        done_next = a_done;
    endtask

    // Start a scan on B, optionally toggling start while the scan is running
    task automatic scan_b(input bit noisy, output int done_cyc, output logic done_next);
        done_cyc = -1;
        @(negedge clk) b_start = 1'b1;
        @(posedge clk);
        @(negedge clk) b_start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_done) begin
                done_cyc = k;
                break;
            end
            b_start = (noisy && k < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        b_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        done_next = b_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_exp = '0; b_exp = '0; c_exp = '0;
        b_fn = '0; c_fn = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_vec, a_busy, a_done, a_tt, a_pass, a_err, a_first} !== '0) begin
            errors++;
            $display("FAIL reset_a: got vec=%0d busy=%b done=%b tt=%h pass=%b err=%0d first=%0d, required all 0",
                     a_vec, a_busy, a_done, a_tt, a_pass, a_err, a_first);
        end
        checks++;
        if ({b_vec, b_busy, b_done, b_tt, b_pass, b_err, b_first} !== '0) begin
            errors++;
            $display("FAIL reset_b: got vec=%0d busy=%b done=%b tt=%h pass=%b err=%0d first=%0d, required all 0",
                     b_vec, b_busy, b_done, b_tt, b_pass, b_err, b_first);
        end
        checks++;
        if ({c_vec, c_busy, c_done, c_tt, c_pass, c_err, c_first} !== '0) begin
            errors++;
            $display("FAIL reset_c: got vec=%0d busy=%b done=%b tt=%h pass=%b err=%0d first=%0d, required all 0",
                     c_vec, c_busy, c_done, c_tt, c_pass, c_err, c_first);
        end
    endtask

    // Scan the 3-input function against a matching or near-matching reference
    task automatic test_scan_a(input logic [7:0] expv, input string name);
        int         done_cyc;
        logic       busy0, done_next;
        logic [7:0] rtt;
        int         e_err, e_first;
        logic       e_pass;
        rtt     = ref_tt3();
        e_err   = CMP ? popcnt16({8'h00, rtt ^ expv}) : 0;
        e_first = CMP ? lowest16({8'h00, rtt ^ expv}) : 0;
        e_pass  = CMP && (e_err == 0);
        a_exp   = expv;
        scan_a(done_cyc, busy0, done_next);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b, required 1", name, busy0);
        end
        checks++;
        if (done_cyc != 24) begin
            errors++;
            $display("FAIL %s done_edge: got %0d, required 24", name, done_cyc);
        end
        checks++;
        if (done_next !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done still %b one cycle later, required 0", name, done_next);
        end
        checks++;
        if (a_tt !== rtt) begin
            errors++;
            $display("FAIL %s table: got %h, required %h", name, a_tt, rtt);
        end
        checks++;
        if (int'(a_err) != e_err || int'(a_first) != e_first) begin
            errors++;
            $display("FAIL %s err_stats: got err=%0d first=%0d, required err=%0d first=%0d",
                     name, a_err, a_first, e_err, e_first);
        end
        checks++;
        if (a_pass !== e_pass) begin
            errors++;
            $display("FAIL %s pass: got %b, required %b", name, a_pass, e_pass);
        end
        checks++;
        if (a_vec !== 3'd7 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_hold: got vec=%0d busy=%b, required vec=7 busy=0", name, a_vec, a_busy);
        end
    endtask

    task automatic test_all_ones();
        int   done_cyc;
        logic done_next;
        b_fn  = 16'hFFFF;
        b_exp = 16'h0000;
        scan_b(1'b0, done_cyc, done_next);
        checks++;
        if (done_cyc != 48 || done_next !== 1'b0) begin
            errors++;
            $display("FAIL all_ones done: got edge=%0d next=%b, required edge=48 next=0", done_cyc, done_next);
        end
        checks++;
        if (b_tt !== 16'hFFFF) begin
            errors++;
            $display("FAIL all_ones table: got %h, required ffff", b_tt);
        end
        checks++;
        if (int'(b_err) != (CMP ? 16 : 0) || b_first !== 4'd0 || b_pass !== 1'b0) begin
            errors++;
            $display("FAIL all_ones stats: got err=%0d first=%0d pass=%b, required err=%0d first=0 pass=0",
                     b_err, b_first, b_pass, CMP ? 16 : 0);
        end
        checks++;
        if (b_vec !== 4'd15) begin
            errors++;
            $display("FAIL all_ones vec_end: got %0d, required 15", b_vec);
        end
    endtask

    // Random functions and references; start toggled randomly during the scan
    task automatic test_random();
        int   done_cyc;
        logic done_next;
        int   e_err, e_first;
        logic e_pass;
        for (int it = 0; it < 6; it++) begin
            b_fn  = 16'($urandom);
            b_exp = (it == 5) ? b_fn : b_fn ^ (16'($urandom) & 16'($urandom));
            e_err   = CMP ? popcnt16(b_fn ^ b_exp) : 0;
            e_first = CMP ? lowest16(b_fn ^ b_exp) : 0;
            e_pass  = CMP && (e_err == 0);
            scan_b(1'b1, done_cyc, done_next);
            checks++;
            if (done_cyc != 48 || done_next !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d] done: got edge=%0d next=%b, required edge=48 next=0",
                         it, done_cyc, done_next);
            end
            checks++;
            if (b_tt !== b_fn) begin
                errors++;
                $display("FAIL random[%0d] table: got %h, required %h", it, b_tt, b_fn);
            end
            checks++;
            if (int'(b_err) != e_err || int'(b_first) != e_first || b_pass !== e_pass) begin
                errors++;
                $display("FAIL random[%0d] stats: got err=%0d first=%0d pass=%b, required err=%0d first=%0d pass=%b",
                         it, b_err, b_first, b_pass, e_err, e_first, e_pass);
            end
        end
    endtask

    // Asynchronous reset mid-scan, then a clean rescan
    task automatic test_reset_mid_scan();
        bit   found, saw_done;
        int   done_cyc;
        logic done_next;
        b_fn  = 16'($urandom);
        b_exp = b_fn;
        found = 1'b0;
        @(negedge clk) b_start = 1'b1;
        @(posedge clk);
        @(negedge clk) b_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b_vec == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid reach_vec5: vec=%0d, required to reach 5", b_vec);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b_vec, b_busy, b_done, b_tt, b_pass, b_err, b_first} !== '0) begin
            errors++;
            $display("FAIL rst_mid async_clear: got vec=%0d busy=%b done=%b tt=%h pass=%b err=%0d first=%0d, required all 0",
                     b_vec, b_busy, b_done, b_tt, b_pass, b_err, b_first);
        end
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b_done || b_busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL rst_mid abandoned: got done/busy activity after reset, required none");
        end
        scan_b(1'b0, done_cyc, done_next);
        checks++;
        if (done_cyc != 48 || b_tt !== b_fn || b_pass !== CMP) begin
            errors++;
            $display("FAIL rst_mid rescan: got edge=%0d tt=%h pass=%b, required edge=48 tt=%h pass=%b",
                     done_cyc, b_tt, b_pass, b_fn, CMP);
        end
    endtask

    // start held high: back-to-back scans on the SETTLE=0 instance
    task automatic test_back_to_back();
        int         first_done, second_done;
        logic [3:0] tt1;
        int         err1, first1;
        logic       pass_mid, busy2;
        int         e_err, e_first;
        logic       e_pass;
        c_fn  = 4'($urandom);
        c_exp = c_fn ^ 4'($urandom);
        e_err   = CMP ? popcnt16({12'h000, c_fn ^ c_exp}) : 0;
        e_first = CMP ? lowest16({12'h000, c_fn ^ c_exp}) : 0;
        e_pass  = CMP && (e_err == 0);
        first_done = -1; second_done = -1;
        tt1 = 'x; err1 = -1; first1 = -1; pass_mid = 1'bx; busy2 = 1'bx;
        @(negedge clk) c_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 2) busy2 = c_busy;
            if (k == 12) pass_mid = c_pass;
            if (c_done) begin
                if (first_done < 0) begin
                    first_done = k;
                    tt1 = c_tt;
                    err1 = int'(c_err);
                    first1 = int'(c_first);
                end else begin
                    second_done = k;
                    c_start = 1'b0;
                    break;
                end
            end
        end
        c_start = 1'b0;
        checks++;
        if (first_done != 8 || second_done != 18) begin
            errors++;
            $display("FAIL b2b done_edges: got %0d,%0d, required 8,18", first_done, second_done);
        end
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b busy: got %b, required 1", busy2);
        end
        checks++;
        if (tt1 !== c_fn || err1 != e_err || first1 != e_first) begin
            errors++;
            $display("FAIL b2b first_scan: got tt=%h err=%0d first=%0d, required tt=%h err=%0d first=%0d",
                     tt1, err1, first1, c_fn, e_err, e_first);
        end
        checks++;
        if (pass_mid !== e_pass) begin
            errors++;
            $display("FAIL b2b pass_hold: got %b, required %b", pass_mid, e_pass);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (c_busy !== 1'b0 || c_done !== 1'b0 || c_vec !== 2'd3 || c_tt !== c_fn) begin
            errors++;
            $display("FAIL b2b idle_after: got busy=%b done=%b vec=%0d tt=%h, required busy=0 done=0 vec=3 tt=%h",
                     c_busy, c_done, c_vec, c_tt, c_fn);
        end
    endtask

    initial begin
        test_reset();
        test_scan_a(8'h4A, "scan_match");
        test_scan_a(8'h4B, "scan_mismatch");
        test_all_ones();
        test_random();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/capture stage for the team's combinational function blocks (gate-level SOP, NAND-only, mux- and decoder-based implementations). On a start request it drives every input combination of an external N-input function in ascending order. After a configurable settle time it samples the function's 1-bit output and assembles the full truth table. Optionally it compares the table against an expected vector and reports pass/fail, mismatch count and first failing index.

## Interface
Parameters:
- N_IN, 4, number of function inputs; legal 1..4.
- SETTLE, 1, extra wait cycles after driving a vector before sampling; legal 0..3.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock domain.
- start  in  1  scan request; sampled only in IDLE.
- expected  in  2**N_IN  reference truth table; bit i = required f for vec == i.
- f_in  in  1  output of the function under scan.
- vec  out  N_IN  input vector driven to the function; vec[N_IN-1] = MSB input (A).
- busy  out  1  high in WAIT and SAMPLE.
- done  out  1  one-cycle pulse, high in DONE.
- table  out  2**N_IN  captured truth table; bit i = f_in sampled for vec == i.
- pass  out  1  1 when last completed scan had zero mismatches.
- err_cnt  out  N_IN+1  mismatch count of last completed scan.
- first_err  out  N_IN  lowest mismatching index; 0 when err_cnt == 0.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start = 1: vec <= 0, table <= 0, err_cnt <= 0, first_err <= 0, settle counter <= SETTLE, go to WAIT. start = 0: stay.
- WAIT, counter == 0: go to SAMPLE. Otherwise decrement. WAIT lasts SETTLE+1 cycles.
- SAMPLE:
  - table[vec] <= f_in.
  - If f_in != expected[vec]: err_cnt <= err_cnt+1.
  - On the first such mismatch, first_err <= vec.
  - If vec == 2**N_IN-1, go to DONE. Otherwise vec <= vec+1, counter <= SETTLE, go to WAIT.
- DONE: done = 1, pass <= (final err_cnt == 0), go to IDLE unconditionally.
- start is ignored in WAIT, SAMPLE and DONE. No queuing.
- Holding start high starts a new scan on the first IDLE cycle after DONE.
- table, err_cnt, first_err update during the scan. pass holds its previous value until DONE.
- All outputs hold after DONE until the next accepted start.
- err_cnt never wraps; its width holds a count of 2**N_IN.
- vec wrap: no increment past 2**N_IN-1; it stays at the last index through DONE and IDLE.

## Timing
- Reset values: vec = 0, busy = 0, done = 0, table = 0, pass = 0, err_cnt = 0, first_err = 0, state IDLE.
- Reset takes effect immediately, including mid-scan. The scan is abandoned with no done pulse.
- Start accepted at edge 0. Vector i is captured at edge (i+1)·(SETTLE+2).
- DONE is entered at edge 2**N_IN·(SETTLE+2); done is high for exactly the following cycle.
- vec changes only on the edge leaving SAMPLE. It is stable for SETTLE+2 cycles before each capture, so f_in must settle within SETTLE+1 cycles.
- f_in is sampled synchronously without a synchronizer; the function block shares clk-domain inputs.
- busy goes high the cycle after start is accepted and falls on entry to DONE.

## Configuration
- SCAN_COMPARE_EN defined: expected is compared; err_cnt, first_err and pass behave as above.
- SCAN_COMPARE_EN undefined: comparison logic is omitted and expected is ignored. err_cnt and first_err are constant 0; pass is constant 0.
- Capture, table, timing and handshake are identical in both builds; ports are retained.

## Test plan
- N_IN=3, SETTLE=1, f = A·B·C' + A'·C, expected = 8'h4A, one start pulse -> table = 8'h4A, err_cnt = 0, first_err = 0, pass = 1, done high exactly in the cycle after edge 24.
- Same function, expected = 8'h4B -> err_cnt = 1, first_err = 0, pass = 0, table = 8'h4A.
- N_IN=4, f_in tied 1, expected = 16'h0000 -> table = 16'hFFFF, err_cnt = 16, first_err = 0, pass = 0; vec ends at 15.
- N_IN=4, rst pulsed while vec = 5 -> all outputs 0 asynchronously, no done. A following start completes a full scan: done after edge 48 with SETTLE=1.
- SETTLE=0, N_IN=2, start held high -> first done after edge 8. The next scan is accepted on the IDLE cycle; start pulses while busy = 1 do not restart or extend the scan.
- Build without SCAN_COMPARE_EN, N_IN=3, same function as the first scenario -> table = 8'h4A, err_cnt = 0, pass = 0, identical done timing.
